// File: rtl/w_normalize_check_pkg.sv
// Shared ICA definitions: Q-format unit, normalize-check FSM encoding, default widths.
package w_normalize_check_pkg;

    localparam int unsigned N_DEF          = 7;
    localparam int unsigned DATA_WIDTH_DEF = 16;
    localparam int unsigned FRAC_WIDTH_DEF = 10;
    localparam int unsigned EPS_DEF        = 8;

    function automatic int unsigned q_one(input int unsigned frac);
        return 32'(1) << frac;
    endfunction

    localparam int unsigned ONE = q_one(FRAC_WIDTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NORM = 3'd1,
        ST_DIV  = 3'd2,
        ST_DOT  = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring signed divider: one quotient bit per cycle, valid DVD_W+1 cycles after start,
// quotient truncated toward zero and saturated to Q_W bits.
module seq_divider #(
    parameter int unsigned DVD_W = 26,
    parameter int unsigned DVS_W = 16,
    parameter int unsigned Q_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             valid_o,
    output logic [Q_W-1:0]   quotient_o
);

    localparam int unsigned R_W   = DVS_W + 1;
    localparam int unsigned CNT_W = $clog2(DVD_W + 1);
    localparam logic [DVD_W-1:0] MAX_POS = DVD_W'((64'(1) << (Q_W - 1)) - 64'(1));
    localparam logic [DVD_W-1:0] MAX_NEG = DVD_W'(64'(1) << (Q_W - 1));

    logic             run_q, fin_q, neg_q, valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic [DVD_W-1:0] dvd_q;
    logic [R_W-1:0]   rem_q, dvs_q;
    logic [Q_W-1:0]   quo_q;

    logic [DVD_W-1:0] dvd_abs_c;
    logic [R_W-1:0]   dvs_ext_c, dvs_abs_c, rem_sh_c;
    logic             sub_ok_c;

    always_comb begin
        dvd_abs_c = dividend_i[DVD_W-1] ? (~dividend_i + DVD_W'(1)) : dividend_i;
        dvs_ext_c = R_W'($signed(divisor_i));
        dvs_abs_c = divisor_i[DVS_W-1] ? (~dvs_ext_c + R_W'(1)) : dvs_ext_c;
        rem_sh_c  = {rem_q[R_W-2:0], dvd_q[DVD_W-1]};
        sub_ok_c  = (rem_sh_c >= dvs_q);
    end

    // dvd_q shifts the dividend out of its MSB while quotient bits shift in at the LSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 1'b0;
            fin_q   <= 1'b0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            if (start_i) begin
                run_q <= 1'b1;
                fin_q <= 1'b0;
                cnt_q <= '0;
                dvd_q <= dvd_abs_c;
                dvs_q <= dvs_abs_c;
                rem_q <= '0;
                neg_q <= dividend_i[DVD_W-1] ^ divisor_i[DVS_W-1];
            end else if (run_q) begin
                dvd_q <= {dvd_q[DVD_W-2:0], sub_ok_c};
                rem_q <= sub_ok_c ? (rem_sh_c - dvs_q) : rem_sh_c;
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DVD_W - 1)) begin
                    run_q <= 1'b0;
                    fin_q <= 1'b1;
                end
            end else if (fin_q) begin
                fin_q   <= 1'b0;
                valid_q <= 1'b1;
                if (!neg_q) begin
                    quo_q <= (dvd_q > MAX_POS) ? MAX_POS[Q_W-1:0] : dvd_q[Q_W-1:0];
                end else begin
                    quo_q <= (dvd_q > MAX_NEG) ? MAX_NEG[Q_W-1:0]
                                               : (~dvd_q[Q_W-1:0] + Q_W'(1));
                end
            end
        end
    end

    assign valid_o    = valid_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/w_normalize_check.sv
// Normalizes an ICA weight vector via the shared vectoring CORDIC and a sequential divider,
// then checks convergence against the previous vector with a dot product.
module w_normalize_check
    import w_normalize_check_pkg::*;
#(
    parameter int unsigned N          = N_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int unsigned EPS        = EPS_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N*DATA_WIDTH-1:0] W_in,
    input  logic [N*DATA_WIDTH-1:0] W_prev,
    input  logic                    cordic_vec_opvld,
    input  logic [DATA_WIDTH-1:0]   cordic_vec_xout,
    output logic                    ica_cordic_vec_en,
    output logic [DATA_WIDTH-1:0]   ica_cordic_vec_xin,
    output logic [DATA_WIDTH-1:0]   ica_cordic_vec_yin,
    output logic                    ica_cordic_vec_angle_calc_en,
    output logic [N*DATA_WIDTH-1:0] W_norm,
    output logic                    converged,
    output logic                    zero_norm,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned ACC_W = 2 * DW + 3;
    localparam int unsigned IDX_W = (N > 2) ? $clog2(N) : 1;
    localparam int unsigned DVD_W = DW + FRAC_WIDTH;
    localparam logic signed [ACC_W-1:0] ONE_A = ACC_W'(q_one(FRAC_WIDTH));
    localparam logic signed [ACC_W-1:0] EPS_A = ACC_W'(EPS);

    state_e                  state_q;
    logic signed [DW-1:0]    w_q  [N];
    logic signed [DW-1:0]    wp_q [N];
    logic signed [DW-1:0]    wn_q [N];
    logic [IDX_W-1:0]        idx_q;
    logic signed [DW-1:0]    norm_q;
    logic signed [ACC_W-1:0] acc_q;
    logic                    en_q, div_start_q, conv_q, zero_q, busy_q, done_q;
    logic [DW-1:0]           xin_q, yin_q;
    logic [N*DW-1:0]         w_norm_q;

    logic                    div_valid;
    logic [DW-1:0]           div_quo;
    logic signed [2*DW-1:0]  prod_c;
    logic signed [ACC_W-1:0] dot_c, dot_abs_c;
    logic                    conv_c;

    seq_divider #(
        .DVD_W (DVD_W),
        .DVS_W (DW),
        .Q_W   (DW)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start_q),
        .dividend_i ({w_q[idx_q], {FRAC_WIDTH{1'b0}}}),
        .divisor_i  (norm_q),
        .valid_o    (div_valid),
        .quotient_o (div_quo)
    );

    // Single shared multiplier; convergence test on the finished accumulator
    always_comb begin
        prod_c    = wn_q[idx_q] * wp_q[idx_q];
        dot_c     = acc_q >>> FRAC_WIDTH;
        dot_abs_c = dot_c[ACC_W-1] ? -dot_c : dot_c;
        conv_c    = (ONE_A - dot_abs_c) <= EPS_A;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            norm_q      <= '0;
            acc_q       <= '0;
            en_q        <= 1'b0;
            div_start_q <= 1'b0;
            conv_q      <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            xin_q       <= '0;
            yin_q       <= '0;
            w_norm_q    <= '0;
            for (int i = 0; i < int'(N); i++) begin
                w_q[i]  <= '0;
                wp_q[i] <= '0;
                wn_q[i] <= '0;
            end
        end else begin
            en_q        <= 1'b0;
            div_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < int'(N); i++) begin
                            w_q[i]  <= $signed(W_in[i*DW +: DW]);
                            wp_q[i] <= $signed(W_prev[i*DW +: DW]);
                        end
                        zero_q  <= 1'b0;
                        acc_q   <= '0;
                        idx_q   <= '0;
                        en_q    <= 1'b1;
                        xin_q   <= W_in[0 +: DW];
                        yin_q   <= W_in[DW +: DW];
                        busy_q  <= 1'b1;
                        state_q <= ST_NORM;
                    end
                end
                // idx_q counts completed vectoring ops; the magnitude chains through yin
                ST_NORM: begin
                    if (cordic_vec_opvld) begin
                        if (idx_q == IDX_W'(N - 2)) begin
                            norm_q <= $signed(cordic_vec_xout);
                            idx_q  <= '0;
                            if (cordic_vec_xout == '0) begin
                                zero_q <= 1'b1;
                                for (int i = 0; i < int'(N); i++) wn_q[i] <= '0;
                                state_q <= ST_FIN;
                            end else begin
                                div_start_q <= 1'b1;
                                state_q     <= ST_DIV;
                            end
                        end else begin
                            en_q  <= 1'b1;
                            xin_q <= w_q[idx_q + IDX_W'(2)];
                            yin_q <= cordic_vec_xout;
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DIV: begin
                    if (div_valid) begin
                        wn_q[idx_q] <= $signed(div_quo);
                        if (idx_q == IDX_W'(N - 1)) begin
                            idx_q   <= '0;
                            state_q <= ST_DOT;
                        end else begin
                            idx_q       <= idx_q + IDX_W'(1);
                            div_start_q <= 1'b1;
                        end
                    end
                end
                ST_DOT: begin
                    acc_q <= acc_q + ACC_W'(prod_c);
                    if (idx_q == IDX_W'(N - 1)) begin
                        idx_q   <= '0;
                        state_q <= ST_FIN;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_FIN: begin
                    for (int i = 0; i < int'(N); i++) w_norm_q[i*DW +: DW] <= wn_q[i];
                    conv_q  <= !zero_q && conv_c;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ica_cordic_vec_en            = en_q;
    assign ica_cordic_vec_xin           = xin_q;
    assign ica_cordic_vec_yin           = yin_q;
    assign ica_cordic_vec_angle_calc_en = 1'b0;
    assign W_norm                       = w_norm_q;
    assign converged                    = conv_q;
    assign zero_norm                    = zero_q;
    assign busy                         = busy_q;
    assign done                         = done_q;

endmodule

// File: doc/w_normalize_check.md
W_NORMALIZE_CHECK -- requirements
Module: w_normalize_check

Interface
REQ-001 Parameters SHALL be: N, 7, vector length; DATA_WIDTH, 16, sample width; FRAC_WIDTH, 10, fraction bits (1.0 = 1024); EPS, 8, convergence tolerance in LSBs.
REQ-002 Ports SHALL be: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  one-cycle pulse, begins a pass on W_in/W_prev.
REQ-004 W_in  in  N*DATA_WIDTH  signed Q vector from the update stage, element i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-005 W_prev  in  N*DATA_WIDTH  previous normalized weight vector, same packing.
REQ-006 cordic_vec_opvld  in  1  / cordic_vec_xout  in  DATA_WIDTH  gain-compensated vectoring magnitude from the shared CORDIC.
REQ-007 ica_cordic_vec_en  out  1  / ica_cordic_vec_xin, ica_cordic_vec_yin  out  DATA_WIDTH  / ica_cordic_vec_angle_calc_en  out  1  shared vectoring CORDIC request.
REQ-008 W_norm  out  N*DATA_WIDTH  normalized vector; converged  out  1; zero_norm  out  1; busy  out  1; done  out  1  one-cycle pulse.

Function
REQ-009 FSM states SHALL be IDLE, NORM, DIV, DOT, FIN; start is accepted only in IDLE and is ignored while busy=1.
REQ-010 On start, W_in and W_prev SHALL be latched internally; busy SHALL be 1 in every state except IDLE.
REQ-011 NORM SHALL issue N-1 vectoring ops: op0 xin=W[0], yin=W[1]; op k (k≥1) xin=W[k+1], yin=previous cordic_vec_xout, each issued the cycle after the prior cordic_vec_opvld; angle_calc_en=0; ica_cordic_vec_en is a one-cycle pulse per op.
REQ-012 The final cordic_vec_xout SHALL be latched as norm; if norm==0, W_norm<=0, zero_norm<=1, converged<=0, and the FSM SHALL go directly to FIN.
REQ-013 DIV SHALL compute W_norm[i] = (W[i] << FRAC_WIDTH) / norm for i=0..N-1 sequentially, signed, truncated toward zero, saturated to DATA_WIDTH.
REQ-014 Each division SHALL take exactly DATA_WIDTH+FRAC_WIDTH+1 cycles from divider start to divider valid.
REQ-015 DOT SHALL accumulate W_norm[i]*W_prev[i], one product per cycle over N cycles, in a 2*DATA_WIDTH+3-bit signed accumulator; dot = acc >>> FRAC_WIDTH.
REQ-016 converged SHALL be 1 iff ((1<<FRAC_WIDTH) - |dot|) <= EPS, sign of dot ignored; a negative difference (|dot| > 1.0) counts as converged.
REQ-017 FIN SHALL pulse done for one cycle, then return to IDLE; W_norm, converged, zero_norm SHALL hold until the next done.
REQ-018 zero_norm SHALL be cleared on the next accepted start.
REQ-019 cordic_vec_opvld arriving outside NORM SHALL be ignored.

Reset
REQ-020 On rst_n low, at any time including mid-pass, the FSM SHALL go to IDLE and all outputs and counters SHALL clear to 0; the divider SHALL abort.
REQ-021 The first start after rst_n release SHALL run a complete, clean pass.

Structure
REQ-022 The Q-format constant ONE=1<<FRAC_WIDTH, the FSM state encoding, and default widths SHALL reside in the shared ICA package.
REQ-023 Division SHALL be a sub-module seq_divider: restoring, one quotient bit per cycle, start/valid handshake, signed operands, saturating output.
REQ-024 One multiplier SHALL be used for DOT; RTL SHALL be 120-400 lines.

Verification
REQ-025 W_in=[3072,4096,0,0,0,0,0], bench CORDIC returns exact magnitudes (5120) -> W_norm=[614,819,0,0,0,0,0]; with W_prev=[614,819,0,...], dot=1023 -> converged=1, done pulse.
REQ-026 Same W_in, W_prev=[-614,-819,0,...] -> dot=-1023 -> converged=1.
REQ-027 Same W_in, W_prev=[0,0,1024,0,0,0,0] -> dot=0 -> converged=0.
REQ-028 W_in all zero -> zero_norm=1, W_norm all 0, converged=0, exactly 6 vectoring requests, no divider activity.
REQ-029 rst_n low during DIV -> outputs 0, busy=0 immediately; next start reproduces REQ-025 result.
REQ-030 Second start pulse during NORM -> ignored; exactly 6 vectoring requests and one done for the pass.
